// File: rtl/push_pull_rr_arbiter.sv
// rtl/push_pull_rr_arbiter.sv - credit-based round-robin arbiter feeding one push-pull sink
//
// Shares one downstream push-pull interface among numRequesters sources.
// Optional burst lock: define PUSH_PULL_ARB_BURST_EN to add parameter burstLen
// and an ARB/LOCK FSM that keeps a grant for up to burstLen consecutive words.
//
// Ports:
//   mclk, reset        clock, asynchronous active-high reset
//   readRun_r          run enable; low flushes arbitration and refills credits
//   enable_r[N]        per-source enable
//   clearErrors_r      clears sticky counterError
//   srcValid[N]        per-source word available
//   srcData[N*W]       per-source data, slice i = [i*W +: W]
//   srcXfer[N]         one-hot combinational pop strobe to the granted source
//   reqFromNext        sink popped one word (credit return)
//   xferToNext         registered push strobe to the sink
//   dataToNext[W]      registered data to the sink
//   grantIdx           index of the last granted source
//   creditCount        free words in the sink fifo
//   counterError       sticky credit-overflow error
module push_pull_rr_arbiter #(
    parameter int dataWidth     = 128,
    parameter int numRequesters = 4,
    parameter int fifoDepth     = 4,
    parameter int noInputRegs   = 0
`ifdef PUSH_PULL_ARB_BURST_EN
    ,
    parameter int burstLen      = 4
`endif
) (
    input  logic                                   mclk,
    input  logic                                   reset,
    input  logic                                   readRun_r,
    input  logic [numRequesters-1:0]               enable_r,
    input  logic                                   clearErrors_r,
    input  logic [numRequesters-1:0]               srcValid,
    input  logic [numRequesters*dataWidth-1:0]     srcData,
    output logic [numRequesters-1:0]               srcXfer,
    input  logic                                   reqFromNext,
    output logic                                   xferToNext,
    output logic [dataWidth-1:0]                   dataToNext,
    output logic [$clog2(numRequesters)-1:0]       grantIdx,
    output logic [$clog2(fifoDepth+1)-1:0]         creditCount,
    output logic                                   counterError
);

    localparam int IW = $clog2(numRequesters);
    localparam int CW = $clog2(fifoDepth + 1);

    logic                     reqFromNext_r;
    logic [numRequesters-1:0] cand;
    logic                     can_send;
    logic                     transfer;
    logic                     credit_full;
    logic                     overflow;
    logic [IW-1:0]            rr_winner;
    logic                     rr_found;
    logic [IW-1:0]            winner;
    logic                     found;

    generate
        if (noInputRegs != 0) begin : g_comb_req
            assign reqFromNext_r = reqFromNext;
        end else begin : g_reg_req
            always_ff @(posedge mclk or posedge reset) begin
                if (reset) reqFromNext_r <= 1'b0;
                else       reqFromNext_r <= reqFromNext;
            end
        end
    endgenerate

    assign cand        = srcValid & enable_r;
    // A credit returning this cycle can be spent immediately, even at zero.
    assign can_send    = readRun_r & ((creditCount != '0) | reqFromNext_r);
    assign credit_full = (creditCount == CW'(fifoDepth));

    // Circular search starting just after the last granted source.
    always_comb begin
        logic [IW-1:0] sel;
        int            idx;
        rr_winner = grantIdx;
        rr_found  = 1'b0;
        for (int k = 1; k <= numRequesters; k++) begin
            idx = (int'(grantIdx) + k) % numRequesters;
            sel = IW'(idx);
            if (!rr_found && cand[sel]) begin
                rr_winner = sel;
                rr_found  = 1'b1;
            end
        end
    end

`ifdef PUSH_PULL_ARB_BURST_EN
    localparam int BW = $clog2(burstLen + 1);

    typedef enum logic {ARB, LOCK} state_t;

    state_t        state, state_next;
    logic [BW-1:0] burst_cnt, burst_cnt_next;
    logic          lock_hold;

    // While locked, grantIdx is the locked source w.
    assign lock_hold = (state == LOCK) && cand[grantIdx];
    assign winner    = lock_hold ? grantIdx : rr_winner;
    assign found     = lock_hold | rr_found;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state     <= ARB;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            burst_cnt <= burst_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        burst_cnt_next = burst_cnt;
        if (!readRun_r) begin
            state_next     = ARB;
            burst_cnt_next = '0;
        end else if (transfer) begin
            if (lock_hold) begin
                if (burst_cnt + BW'(1) >= BW'(burstLen)) begin
                    state_next     = ARB;
                    burst_cnt_next = '0;
                end else begin
                    burst_cnt_next = burst_cnt + BW'(1);
                end
            end else if (burstLen > 1) begin
                state_next     = LOCK;
                burst_cnt_next = BW'(1);
            end else begin
                state_next     = ARB;
                burst_cnt_next = '0;
            end
        end else if (state == LOCK && !lock_hold) begin
            // Locked source dropped valid or was disabled; no-credit cycles stay locked.
            state_next     = ARB;
            burst_cnt_next = '0;
        end
    end
`else
    assign winner = rr_winner;
    assign found  = rr_found;
`endif

    assign transfer = can_send & found;
    // Overflow detection is masked while the run enable is low.
    assign overflow = readRun_r & reqFromNext_r & ~transfer & credit_full;

    always_comb begin
        srcXfer = '0;
        if (transfer) srcXfer[winner] = 1'b1;
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            xferToNext   <= 1'b0;
            dataToNext   <= '0;
            grantIdx     <= IW'(numRequesters - 1);
            creditCount  <= CW'(fifoDepth);
            counterError <= 1'b0;
        end else begin
            xferToNext <= transfer;
            if (transfer) begin
                dataToNext <= srcData[winner*dataWidth +: dataWidth];
                grantIdx   <= winner;
            end
            if (!readRun_r)
                creditCount <= CW'(fifoDepth);
            else if (transfer && !reqFromNext_r)
                creditCount <= creditCount - CW'(1);
            else if (!transfer && reqFromNext_r && !credit_full)
                creditCount <= creditCount + CW'(1);
            counterError <= (counterError & ~clearErrors_r) | overflow;
        end
    end

endmodule

// File: tb/tb_push_pull_rr_arbiter.sv
// tb/tb_push_pull_rr_arbiter.sv - directed self-checking bench for push_pull_rr_arbiter
module tb_push_pull_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
`ifdef PUSH_PULL_ARB_BURST_EN
    localparam int B  = 4;
`else
    localparam int B  = 1;
`endif

    logic           mclk = 1'b0;
    logic           reset;
    logic           readRun_r;
    logic [N-1:0]   enable_r;
    logic           clearErrors_r;
    logic [N-1:0]   srcValid;
    logic [N*W-1:0] srcData;
    logic [N-1:0]   srcXfer;
    logic           reqFromNext;
    logic           xferToNext;
    logic [W-1:0]   dataToNext;
    logic [1:0]     grantIdx;
    logic [2:0]     creditCount;
    logic           counterError;

    int checks = 0;
    int passes = 0;

    push_pull_rr_arbiter #(
        .dataWidth(W), .numRequesters(N), .fifoDepth(4), .noInputRegs(0)
    ) dut (
        .mclk(mclk), .reset(reset), .readRun_r(readRun_r), .enable_r(enable_r),
        .clearErrors_r(clearErrors_r), .srcValid(srcValid), .srcData(srcData),
        .srcXfer(srcXfer), .reqFromNext(reqFromNext), .xferToNext(xferToNext),
        .dataToNext(dataToNext), .grantIdx(grantIdx), .creditCount(creditCount),
        .counterError(counterError)
    );

    always #5 mclk = ~mclk;

    task tick;
        @(posedge mclk);
        #1;
    endtask

    task test_reset;
        reset = 1'b1; readRun_r = 1'b0; enable_r = '0; clearErrors_r = 1'b0;
        srcValid = '0; reqFromNext = 1'b0;
        for (int i = 0; i < N; i++) srcData[i*W +: W] = 16'hA0A0 + 16'(i);
        #2;
        checks++; if (xferToNext !== 1'b0) $display("FAIL reset_xfer got=%b exp=0", xferToNext); else passes++;
        checks++; if (dataToNext !== 16'h0) $display("FAIL reset_data got=%h exp=0", dataToNext); else passes++;
        checks++; if (grantIdx !== 2'd3) $display("FAIL reset_grant got=%0d exp=3", grantIdx); else passes++;
        checks++; if (creditCount !== 3'd4) $display("FAIL reset_credit got=%0d exp=4", creditCount); else passes++;
        checks++; if (counterError !== 1'b0) $display("FAIL reset_err got=%b exp=0", counterError); else passes++;
        tick;
        reset = 1'b0; readRun_r = 1'b1; enable_r = 4'hF;
        #1;
        checks++; if (srcXfer !== 4'b0000) $display("FAIL reset_srcxfer got=%b exp=0000", srcXfer); else passes++;
    endtask

    task test_fairness;
        int e;
        srcValid = 4'hF; reqFromNext = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = (k / B) % N;
            #1;
            checks++; if (srcXfer !== 4'(1 << e)) $display("FAIL fair_srcxfer k=%0d got=%b exp=%b", k, srcXfer, 4'(1 << e)); else passes++;
            tick;
            checks++;
            if (xferToNext !== 1'b1 || grantIdx !== 2'(e) || dataToNext !== 16'hA0A0 + 16'(e))
                $display("FAIL fair_out k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, xferToNext, grantIdx, dataToNext, e, 16'hA0A0 + 16'(e));
            else passes++;
            checks++; if (creditCount !== 3'd3) $display("FAIL fair_credit k=%0d got=%0d exp=3", k, creditCount); else passes++;
        end
        srcValid = '0; reqFromNext = 1'b0;
        tick; tick;
        checks++; if (creditCount !== 3'd4 || xferToNext !== 1'b0) $display("FAIL fair_idle got=%0d/%b exp=4/0", creditCount, xferToNext); else passes++;
    endtask

    task test_exhaustion;
        srcValid = 4'b0100; reqFromNext = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (srcXfer !== 4'b0100) $display("FAIL exh_srcxfer k=%0d got=%b exp=0100", k, srcXfer); else passes++;
            tick;
            checks++; if (creditCount !== 3'(3 - k) || xferToNext !== 1'b1) $display("FAIL exh_credit k=%0d got=%0d/%b exp=%0d/1", k, creditCount, xferToNext, 3 - k); else passes++;
        end
        #1;
        checks++; if (srcXfer !== 4'b0000) $display("FAIL exh_stall got=%b exp=0000", srcXfer); else passes++;
        tick;
        checks++; if (xferToNext !== 1'b0 || creditCount !== 3'd0) $display("FAIL exh_empty got=%b/%0d exp=0/0", xferToNext, creditCount); else passes++;
        reqFromNext = 1'b1;
        #1;
        checks++; if (srcXfer !== 4'b0000) $display("FAIL exh_pop_lat got=%b exp=0000", srcXfer); else passes++;
        tick;
        reqFromNext = 1'b0;
        #1;
        checks++; if (srcXfer !== 4'b0100) $display("FAIL pushpop_srcxfer got=%b exp=0100", srcXfer); else passes++;
        tick;
        checks++; if (xferToNext !== 1'b1 || creditCount !== 3'd0) $display("FAIL pushpop_out got=%b/%0d exp=1/0", xferToNext, creditCount); else passes++;
        #1;
        checks++; if (srcXfer !== 4'b0000) $display("FAIL exh_after got=%b exp=0000", srcXfer); else passes++;
        srcValid = '0; readRun_r = 1'b0;
        tick;
        readRun_r = 1'b1;
        checks++; if (creditCount !== 3'd4) $display("FAIL exh_refill got=%0d exp=4", creditCount); else passes++;
    endtask

    task test_run_drop;
        srcValid = 4'b0001;
        for (int k = 0; k < 3; k++) tick;
        checks++; if (creditCount !== 3'd1 || grantIdx !== 2'd0) $display("FAIL run_pre got=%0d/%0d exp=1/0", creditCount, grantIdx); else passes++;
        readRun_r = 1'b0;
        #1;
        checks++; if (srcXfer !== 4'b0000) $display("FAIL run_srcxfer got=%b exp=0000", srcXfer); else passes++;
        tick;
        checks++;
        if (xferToNext !== 1'b0 || creditCount !== 3'd4 || grantIdx !== 2'd0)
            $display("FAIL run_out got=%b/%0d/%0d exp=0/4/0", xferToNext, creditCount, grantIdx);
        else passes++;
        readRun_r = 1'b1; srcValid = '0;
        tick;
    endtask

    task test_enable_drop;
        srcValid = 4'b0011; enable_r = 4'hF;
        #1;
        checks++; if (srcXfer !== 4'b0010) $display("FAIL en_first got=%b exp=0010", srcXfer); else passes++;
        tick;
        checks++; if (grantIdx !== 2'd1 || dataToNext !== 16'hA0A1 || creditCount !== 3'd3) $display("FAIL en_first_out got=%0d/%h/%0d exp=1/a0a1/3", grantIdx, dataToNext, creditCount); else passes++;
        enable_r = 4'b1101;
        #1;
        checks++; if (srcXfer !== 4'b0001) $display("FAIL en_drop got=%b exp=0001", srcXfer); else passes++;
        tick;
        checks++; if (grantIdx !== 2'd0 || creditCount !== 3'd2) $display("FAIL en_drop_out got=%0d/%0d exp=0/2", grantIdx, creditCount); else passes++;
        srcValid = '0; enable_r = 4'hF;
        tick;
    endtask

    task test_overflow;
        readRun_r = 1'b0;
        tick;
        readRun_r = 1'b1;
        reqFromNext = 1'b1;
        tick;
        reqFromNext = 1'b0;
        tick;
        checks++; if (counterError !== 1'b1 || creditCount !== 3'd4) $display("FAIL ovf_set got=%b/%0d exp=1/4", counterError, creditCount); else passes++;
        tick;
        checks++; if (counterError !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", counterError); else passes++;
        clearErrors_r = 1'b1;
        tick;
        clearErrors_r = 1'b0;
        checks++; if (counterError !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", counterError); else passes++;
        reqFromNext = 1'b1;
        tick;
        reqFromNext = 1'b0; clearErrors_r = 1'b1;
        tick;
        checks++; if (counterError !== 1'b1) $display("FAIL ovf_set_wins got=%b exp=1", counterError); else passes++;
        tick;
        clearErrors_r = 1'b0;
        checks++; if (counterError !== 1'b0) $display("FAIL ovf_clear2 got=%b exp=0", counterError); else passes++;
    endtask

    task test_burst_sequence;
        int e;
        readRun_r = 1'b0;
        tick;
        readRun_r = 1'b1; srcValid = 4'b0011; reqFromNext = 1'b1;
        for (int k = 0; k < 9; k++) begin
            e = ((k / B) + 1) % 2;
            #1;
            checks++; if (srcXfer !== 4'(1 << e)) $display("FAIL seq_srcxfer k=%0d got=%b exp=%b", k, srcXfer, 4'(1 << e)); else passes++;
            tick;
            checks++; if (grantIdx !== 2'(e)) $display("FAIL seq_grant k=%0d got=%0d exp=%0d", k, grantIdx, e); else passes++;
        end
        srcValid = '0; reqFromNext = 1'b0;
        tick; tick;
    endtask

    task test_reset_mid;
        srcValid = 4'b1000;
        #1;
        checks++; if (srcXfer !== 4'b1000) $display("FAIL mid_srcxfer got=%b exp=1000", srcXfer); else passes++;
        tick;
        srcValid = '0;
        checks++; if (xferToNext !== 1'b1) $display("FAIL mid_inflight got=%b exp=1", xferToNext); else passes++;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (xferToNext !== 1'b0 || grantIdx !== 2'd3 || creditCount !== 3'd4 || dataToNext !== 16'h0)
            $display("FAIL mid_reset got=%b/%0d/%0d/%h exp=0/3/4/0", xferToNext, grantIdx, creditCount, dataToNext);
        else passes++;
        tick;
        reset = 1'b0;
        tick;
        checks++; if (xferToNext !== 1'b0) $display("FAIL mid_after got=%b exp=0", xferToNext); else passes++;
    endtask

    initial begin
        test_reset;
        test_fairness;
        test_exhaustion;
        test_run_drop;
        test_enable_drop;
        test_overflow;
        test_burst_sequence;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
